// File: rtl/mlp_feature_loader.sv
// Front-end for the printed-MLP classifier: quantizes a serial sample stream into
// one flat feature frame, holds it while the classifier settles, and returns the class.
module mlp_feature_loader #(
    parameter int N_FEAT   = 6,
    parameter int IN_W     = 8,
    parameter int Q_W      = 4,
    parameter int EVAL_CYC = 2,
    parameter int CLS_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic [N_FEAT*Q_W-1:0]   mlp_inp,
    input  logic [CLS_W-1:0]        mlp_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CLS_W-1:0]        m_class,
    output logic                    frame_err
);

    localparam int SH    = IN_W - Q_W;
    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int CNT_W = $clog2(EVAL_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [IN_W:0]    RND      = (IN_W + 1)'(1) << (SH - 1);

    typedef enum logic [1:0] {COLLECT, DRAIN, EVAL, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_hs, wr_en, cap_en, err_d;
    logic [IN_W:0]    q_sum;
    logic [Q_W:0]     q_shift;
    logic [Q_W-1:0]   q_val;

    // Both ports use plain valid/ready: a beat or result transfers on the rising edge
    // where valid and ready are both high; valid never depends on ready.
    assign s_ready = !rst && (state_q == COLLECT || state_q == DRAIN);
    assign m_valid = (state_q == HOLD);
    assign s_hs    = s_valid && s_ready;

    // The shifted sum can only reach exactly 2^Q_W, so its top bit flags saturation.
    assign q_sum   = {1'b0, s_data} + RND;
    assign q_shift = q_sum[IN_W:SH];
    assign q_val   = q_shift[Q_W] ? {Q_W{1'b1}} : q_shift[Q_W-1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        cap_en  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (s_hs) begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        if (s_last) begin
                            state_d = EVAL;
                            cnt_d   = CNT_W'(EVAL_CYC);
                        end else begin
                            err_d   = 1'b1;
                            idx_d   = '0;
                            state_d = DRAIN;
                        end
                    end else if (s_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (s_hs && s_last) state_d = COLLECT;
            end
            EVAL: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    cap_en  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            cnt_q     <= '0;
            mlp_inp   <= '0;
            m_class   <= '0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            frame_err <= err_d;
            if (cap_en) m_class <= mlp_out;
            if (wr_en) begin
                for (int k = 0; k < N_FEAT; k++) begin
                    if (idx_q == IDX_W'(k)) mlp_inp[k*Q_W +: Q_W] <= q_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_feature_loader.sv
// Bench for mlp_feature_loader: directed scenarios plus random frames checked
// against an arithmetic model of quantization, frame assembly and result timing.
module tb_mlp_feature_loader;

    localparam int N_FEAT   = 6;
    localparam int IN_W     = 8;
    localparam int Q_W      = 4;
    localparam int EVAL_CYC = 2;
    localparam int CLS_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  s_valid, s_ready, s_last;
    logic [IN_W-1:0]       s_data;
    logic [N_FEAT*Q_W-1:0] mlp_inp;
    logic [CLS_W-1:0]      mlp_out, m_class;
    logic                  m_valid, m_ready, frame_err;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    bit rand_out = 1'b0;
    logic [IN_W-1:0] smp[16];
    int slot_model[N_FEAT];

    mlp_feature_loader #(
        .N_FEAT(N_FEAT), .IN_W(IN_W), .Q_W(Q_W), .EVAL_CYC(EVAL_CYC), .CLS_W(CLS_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mlp_inp(mlp_inp), .mlp_out(mlp_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .frame_err(frame_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic int quant(input int d);
        int q;
        q = (d + 2 ** (IN_W - Q_W - 1)) / (2 ** (IN_W - Q_W));
        return (q > 2 ** Q_W - 1) ? 2 ** Q_W - 1 : q;
    endfunction

    function automatic logic [N_FEAT*Q_W-1:0] model_vec();
        longint acc;
        acc = 0;
        for (int k = 0; k < N_FEAT; k++) acc += longint'(slot_model[k]) * (longint'(1) << (k * Q_W));
        return acc[N_FEAT*Q_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_out) mlp_out = CLS_W'($urandom);
    endtask

    task automatic send_frame(input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_data  = smp[i];
            s_last  = (i == n - 1);
            g = 0;
            while (s_ready !== 1'b1 && g < 20) begin
                tick();
                g++;
            end
            if (g == 20) chk("s_ready_timeout", 64'(s_ready), 64'd1);
            tick();
            if (i < N_FEAT) slot_model[i] = quant(int'(smp[i]));
            chk("frame_err_beat", 64'(frame_err),
                ((i == n - 1 && n < N_FEAT) || (i == N_FEAT - 1 && n > N_FEAT)) ? 64'd1 : 64'd0);
            chk("m_valid_collect", 64'(m_valid), 64'd0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called right after the last beat's handshake edge.
    task automatic eval_and_hold(input int hold_cyc);
        logic [CLS_W-1:0]      exp_cls;
        logic [N_FEAT*Q_W-1:0] exp_vec;
        exp_vec = model_vec();
        exp_cls = '0;
        for (int c = 1; c <= EVAL_CYC; c++) begin
            chk("s_ready_eval", 64'(s_ready), 64'd0);
            chk("mlp_inp_eval", 64'(mlp_inp), 64'(exp_vec));
            chk("m_valid_eval", 64'(m_valid), 64'd0);
            exp_cls = mlp_out;
            tick();
        end
        for (int h = 0; h < hold_cyc; h++) begin
            chk("m_valid_hold", 64'(m_valid), 64'd1);
            chk("m_class_hold", 64'(m_class), 64'(exp_cls));
            chk("s_ready_hold", 64'(s_ready), 64'd0);
            chk("mlp_inp_hold", 64'(mlp_inp), 64'(exp_vec));
            tick();
        end
        chk("m_valid_result", 64'(m_valid), 64'd1);
        chk("m_class_result", 64'(m_class), 64'(exp_cls));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("m_valid_after_ack", 64'(m_valid), 64'd0);
        chk("s_ready_after_ack", 64'(s_ready), 64'd1);
    endtask

    task automatic expect_no_result(input int base_err);
        for (int c = 0; c < 4; c++) begin
            chk("m_valid_no_result", 64'(m_valid), 64'd0);
            tick();
        end
        chk("err_pulse_count", 64'(err_pulses - base_err), 64'd1);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0:       smp[i] = IN_W'($urandom_range(0, 7));
                1:       smp[i] = IN_W'($urandom_range(2 ** IN_W - 9, 2 ** IN_W - 1));
                default: smp[i] = IN_W'($urandom);
            endcase
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int base;
        int n;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b0; mlp_out = '0;
        for (int k = 0; k < N_FEAT; k++) slot_model[k] = 0;

        tick(); tick(); tick();
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_mlp_inp", 64'(mlp_inp), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_class", 64'(m_class), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        rst = 1'b0;
        #1;
        chk("s_ready_after_rst", 64'(s_ready), 64'd1);

        // Reference frame with a fixed classifier answer.
        smp[0] = 8'h18; smp[1] = 8'h00; smp[2] = 8'hF8;
        smp[3] = 8'h7F; smp[4] = 8'h40; smp[5] = 8'h08;
        mlp_out = 2'b10;
        send_frame(6);
        chk("ref_mlp_inp", 64'(mlp_inp), 64'h148F02);
        eval_and_hold(5);

        rand_out = 1'b1;

        // Short frame, then a good one.
        base = err_pulses;
        fill_random(3);
        send_frame(3);
        expect_no_result(base);
        fill_random(6);
        send_frame(6);
        eval_and_hold(0);

        // Long frame, then a good one.
        base = err_pulses;
        fill_random(8);
        send_frame(8);
        expect_no_result(base);
        fill_random(6);
        send_frame(6);
        eval_and_hold(1);

        // Rounding and saturation sweep.
        smp[0] = 8'hFF; smp[1] = 8'hF7; smp[2] = 8'h07; smp[3] = 8'h08;
        smp[4] = IN_W'($urandom); smp[5] = IN_W'($urandom);
        send_frame(6);
        chk("sweep_slot0", 64'(mlp_inp[0*Q_W +: Q_W]), 64'd15);
        chk("sweep_slot1", 64'(mlp_inp[1*Q_W +: Q_W]), 64'd15);
        chk("sweep_slot2", 64'(mlp_inp[2*Q_W +: Q_W]), 64'd0);
        chk("sweep_slot3", 64'(mlp_inp[3*Q_W +: Q_W]), 64'd1);
        eval_and_hold(2);

        // Reset while the classifier is settling on its final count.
        fill_random(6);
        send_frame(6);
        tick();
        rst = 1'b1;
        tick();
        for (int k = 0; k < N_FEAT; k++) slot_model[k] = 0;
        chk("rst_eval_m_valid", 64'(m_valid), 64'd0);
        chk("rst_eval_m_class", 64'(m_class), 64'd0);
        chk("rst_eval_mlp_inp", 64'(mlp_inp), 64'd0);
        chk("rst_eval_frame_err", 64'(frame_err), 64'd0);
        chk("rst_eval_s_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_eval_s_ready_rel", 64'(s_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_eval_no_result", 64'(m_valid), 64'd0);
        end

        // Random frames of mixed lengths.
        for (int f = 0; f < 12; f++) begin
            case ($urandom_range(0, 4))
                0:       n = $urandom_range(1, N_FEAT - 1);
                1:       n = $urandom_range(N_FEAT + 1, 10);
                default: n = N_FEAT;
            endcase
            base = err_pulses;
            fill_random(n);
            send_frame(n);
            if (n == N_FEAT) eval_and_hold($urandom_range(0, 3));
            else expect_no_result(base);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
